// File: rtl/pipe_stage_chain.sv
// Elastic register-slice chain: DEPTH stages of WIDTH-bit data with valid/ready flow control,
// bubble collapse and synchronous flush. Define PIPE_OCC_EN to add the occ output.
module pipe_stage_chain #(
  parameter int unsigned      WIDTH   = 16,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  if (DEPTH < 1) begin : gen_depth_chk
    $error("pipe_stage_chain: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] enter;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic             in_fire;

  // A stage advances when it is valid and anything downstream has room: either an empty stage
  // further on or the output being consumed. Scanning from the output end avoids a
  // self-referencing ready chain while giving the same result.
  always_comb begin
    logic space;
    space = out_ready;
    adv   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i] = valid_q[i] & space;
      space  = space | ~valid_q[i];
    end
  end

  assign in_ready = ~rst & ~flush & (~valid_q[0] | adv[0]);
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    enter    = '0;
    enter[0] = in_fire;
    for (int i = 1; i < DEPTH; i++) begin
      enter[i] = adv[i-1];
    end
  end

  // Flush drops occupancy but leaves data registers untouched.
  always_comb begin
    if (flush) begin
      valid_d = '0;
    end else begin
      valid_d = enter | (valid_q & ~adv);
    end
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
      if (enter[i] && !flush) begin
        data_d[i] = (i == 0) ? in_data : data_q[(i == 0) ? 0 : i - 1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RST_VAL;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

`ifdef PIPE_OCC_EN
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OccW'(valid_q[i]);
    end
  end
`endif

`ifndef SYNTHESIS
  // A stalled output must hold its data; a flush must empty the last stage.
  stall_hold_a : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));
  flush_empty_a : assert property (@(posedge clk) disable iff (rst)
    flush |=> !out_valid);
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain: directed scenarios plus random traffic, checked
// against a queue model of in-flight items with per-item arrival times.
module tb_pipe_stage_chain;

  localparam int unsigned W   = 16;
  localparam int unsigned D   = 2;
  localparam int unsigned D4  = 4;
  localparam logic [W-1:0] RV = 16'hA5A5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] out_data;

  logic in4_valid = 1'b0;
  logic in4_ready;
  logic [W-1:0] in4_data = '0;
  logic out4_valid;
  logic out4_ready = 1'b0;
  logic [W-1:0] out4_data;

`ifdef PIPE_OCC_EN
  logic [1:0] occ;
  logic [2:0] occ4;
`endif

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_OCC_EN
    ,
    .occ       (occ)
`endif
  );

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D4), .RST_VAL(RV)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .in_valid  (in4_valid),
    .in_ready  (in4_ready),
    .in_data   (in4_data),
    .out_valid (out4_valid),
    .out_ready (out4_ready),
    .out_data  (out4_data)
`ifdef PIPE_OCC_EN
    ,
    .occ       (occ4)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           ready_at;
  } item_t;

  item_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Sampled mid-cycle: inputs and outputs here are exactly what the next posedge will act on.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("in_ready", 32'(in_ready),
          32'(!flush && (exp_q.size() < D || out_ready)));
      chk("out_valid", 32'(out_valid),
          32'(exp_q.size() != 0 && cyc >= exp_q[0].ready_at));
`ifdef PIPE_OCC_EN
      chk("occ", 32'(occ), 32'(exp_q.size()));
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q[0].data));
          void'(exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
      if (in_valid && in_ready) begin
        item_t it;
        it.data     = in_data;
        it.ready_at = cyc + D;
        exp_q.push_back(it);
      end
    end
  end

  // Called at posedge+1: apply inputs for the coming cycle, then advance one edge.
  task automatic step(input logic iv, input logic [W-1:0] dat, input logic ordy,
                      input logic fl);
    in_valid  = iv;
    in_data   = dat;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset / idle
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'(RV));
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming
    for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure / full
    step(1'b1, 16'h0011, 1'b0, 1'b0);
    step(1'b1, 16'h0012, 1'b0, 1'b0);
    step(1'b1, 16'h0013, 1'b0, 1'b0);
    step(1'b1, 16'h0013, 1'b0, 1'b0);
    chk("full_out_data", 32'(out_data), 32'h0011);
    step(1'b1, 16'h0013, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Bubble collapse on the deep instance
    in4_valid  = 1'b1;
    in4_data   = 16'h1234;
    out4_ready = 1'b0;
    @(posedge clk);
    #1 in4_valid = 1'b0;
    for (int e = 1; e < 4; e++) begin
      chk("bubble_early", 32'(out4_valid), 32'd0);
      step(1'b0, '0, 1'b0, 1'b0);
    end
    chk("bubble_valid", 32'(out4_valid), 32'd1);
    chk("bubble_data", 32'(out4_data), 32'h1234);

    // Flush with a full chain and a pending input
    step(1'b1, 16'h0021, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, 1'b0);
    step(1'b1, 16'h0099, 1'b0, 1'b1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    step(1'b1, 16'h0031, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Async reset while full
    step(1'b1, 16'h0041, 1'b0, 1'b0);
    step(1'b1, 16'h0042, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'(RV));
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_release_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
